// File: rtl/axi_lite_apb_bridge_n.sv
// AXI-Lite slave to N-port APB3/APB4 master bridge with a uniform slot map,
// read/write round-robin arbitration, PREADY timeout and DECERR for unmapped addresses.
module axi_lite_apb_bridge_n #(
   parameter int          apb_slave_n       = 4,
   parameter logic [31:0] apb_base_addr     = 32'h4000_0000,
   parameter int          apb_slot_log2     = 12,
   parameter int          pready_timeout_th = 64,
   parameter int          simulation_delay  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [31:0]               s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [31:0]               s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [31:0]               s_axi_wdata,
   input  logic [3:0]                s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic [31:0]               m_apb_paddr,
   output logic                      m_apb_pwrite,
   output logic                      m_apb_penable,
   output logic [3:0]                m_apb_pstrb,
   output logic [31:0]               m_apb_pwdata,
   output logic [2:0]                m_apb_pprot,
   output logic [apb_slave_n-1:0]    m_apb_psel,
   input  logic [apb_slave_n-1:0]    m_apb_pready,
   input  logic [apb_slave_n-1:0]    m_apb_pslverr,
   input  logic [32*apb_slave_n-1:0] m_apb_prdata,
   output logic                      timeout_flag,
   output logic [1:0]                fsm_state
);

   localparam int IW = (apb_slave_n > 1) ? $clog2(apb_slave_n) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t        state, next_state;
   logic          last_read, is_write;
   logic [IW-1:0] idx_q;
   logic [31:0]   wait_cnt;
   logic [1:0]    resp_q;
   logic [31:0]   rdata_q;

   logic          rd_req, wr_req, grant_read, grant_write, handshake, hit;
   logic [31:0]   req_addr, offset, slot;
   logic          sel_pready, sel_pslverr, timeout_hit;
   logic [31:0]   sel_prdata;

   // The delay parameter only affects behavioural models; it has no hardware meaning here.
   logic [31:0]   unused_sim_delay;
   assign unused_sim_delay = simulation_delay;

   // Round-robin: with both kinds pending, the kind not granted last wins; read wins after reset.
   always_comb begin
      rd_req        = s_axi_arvalid;
      wr_req        = s_axi_awvalid && s_axi_wvalid;
      grant_write   = wr_req && (!rd_req || last_read);
      grant_read    = rd_req && !grant_write;
      s_axi_arready = !rst && (state == IDLE) && grant_read;
      s_axi_awready = !rst && (state == IDLE) && grant_write;
      s_axi_wready  = s_axi_awready;
      handshake     = s_axi_arready || s_axi_awready;
      req_addr      = grant_write ? s_axi_awaddr : s_axi_araddr;
      offset        = req_addr - apb_base_addr;
      slot          = offset >> apb_slot_log2;
      hit           = (req_addr >= apb_base_addr) && (slot < 32'(apb_slave_n));
   end

   always_comb begin
      sel_pready  = m_apb_pready[idx_q];
      sel_pslverr = m_apb_pslverr[idx_q];
      sel_prdata  = m_apb_prdata[32*idx_q +: 32];
      timeout_hit = (pready_timeout_th != 0) && (wait_cnt == 32'(pready_timeout_th - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (handshake) next_state = hit ? SETUP : RESP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (sel_pready || timeout_hit) next_state = RESP;
         RESP:    if (is_write ? s_axi_bready : s_axi_rready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      s_axi_rvalid  = (state == RESP) && !is_write;
      s_axi_bvalid  = (state == RESP) && is_write;
      s_axi_rdata   = rdata_q;
      s_axi_rresp   = resp_q;
      s_axi_bresp   = resp_q;
      m_apb_penable = (state == ACCESS);
      m_apb_pprot   = 3'b000;
      fsm_state     = state;
      for (int i = 0; i < apb_slave_n; i++)
         m_apb_psel[i] = ((state == SETUP) || (state == ACCESS)) && (idx_q == IW'(i));
   end

   // APB address/data only change on a mapped grant, so they hold their last value otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_read    <= 1'b0;
         is_write     <= 1'b0;
         idx_q        <= '0;
         wait_cnt     <= '0;
         resp_q       <= 2'b00;
         rdata_q      <= '0;
         m_apb_paddr  <= '0;
         m_apb_pwrite <= 1'b0;
         m_apb_pwdata <= '0;
         m_apb_pstrb  <= '0;
         timeout_flag <= 1'b0;
      end else begin
         timeout_flag <= 1'b0;
         case (state)
            IDLE: if (handshake) begin
               last_read <= grant_read;
               is_write  <= grant_write;
               wait_cnt  <= '0;
               if (hit) begin
                  idx_q        <= slot[IW-1:0];
                  m_apb_paddr  <= req_addr;
                  m_apb_pwrite <= grant_write;
                  m_apb_pstrb  <= grant_write ? s_axi_wstrb : 4'b0000;
                  if (grant_write) m_apb_pwdata <= s_axi_wdata;
               end else begin
                  resp_q  <= 2'b11;
                  rdata_q <= '0;
               end
            end
            ACCESS: begin
               if (sel_pready) begin
                  rdata_q <= sel_prdata;
                  resp_q  <= sel_pslverr ? 2'b10 : 2'b00;
               end else if (timeout_hit) begin
                  timeout_flag <= 1'b1;
                  resp_q       <= 2'b10;
                  rdata_q      <= 32'hDEAD_BEEF;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_apb_bridge_n.sv
// Directed bench for axi_lite_apb_bridge_n: latency, wait states, decode misses,
// read/write alternation, PREADY timeout and mid-transfer reset.
module tb_axi_lite_apb_bridge_n;

   localparam int N = 4;

   logic           clk, rst;
   logic [31:0]    s_axi_araddr;
   logic           s_axi_arvalid, s_axi_arready;
   logic [31:0]    s_axi_rdata;
   logic [1:0]     s_axi_rresp;
   logic           s_axi_rvalid, s_axi_rready;
   logic [31:0]    s_axi_awaddr;
   logic           s_axi_awvalid, s_axi_awready;
   logic [31:0]    s_axi_wdata;
   logic [3:0]     s_axi_wstrb;
   logic           s_axi_wvalid, s_axi_wready;
   logic [1:0]     s_axi_bresp;
   logic           s_axi_bvalid, s_axi_bready;
   logic [31:0]    m_apb_paddr;
   logic           m_apb_pwrite, m_apb_penable;
   logic [3:0]     m_apb_pstrb;
   logic [31:0]    m_apb_pwdata;
   logic [2:0]     m_apb_pprot;
   logic [N-1:0]   m_apb_psel, m_apb_pready, m_apb_pslverr;
   logic [32*N-1:0] m_apb_prdata;
   logic           timeout_flag;
   logic [1:0]     fsm_state;

   int passed = 0;
   int total  = 0;

   axi_lite_apb_bridge_n #(
      .apb_slave_n(N), .apb_base_addr(32'h4000_0000), .apb_slot_log2(12),
      .pready_timeout_th(8), .simulation_delay(0)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .m_apb_paddr(m_apb_paddr), .m_apb_pwrite(m_apb_pwrite), .m_apb_penable(m_apb_penable),
      .m_apb_pstrb(m_apb_pstrb), .m_apb_pwdata(m_apb_pwdata), .m_apb_pprot(m_apb_pprot),
      .m_apb_psel(m_apb_psel), .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr),
      .m_apb_prdata(m_apb_prdata), .timeout_flag(timeout_flag), .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_araddr = '0; s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_rready = 1'b1; s_axi_bready = 1'b1;
      m_apb_pready = '0; m_apb_pslverr = '0; m_apb_prdata = '0;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] all_outputs();
      return {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid,
              m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata,
              m_apb_pstrb, s_axi_rdata, s_axi_rresp, s_axi_bresp, timeout_flag};
   endfunction

   logic exp_q[$];
   int   grants, both, pen_cnt, to_cnt, seen;

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      check("reset_outputs", all_outputs(), '0);
      check("reset_state", fsm_state, 2'd0);
      check("pprot_zero", m_apb_pprot, 3'b000);
      rst = 1'b0;
      tick();

      // Zero-wait read from slave 1
      s_axi_araddr = 32'h4000_1004; s_axi_arvalid = 1'b1;
      m_apb_pready = 4'b0010; m_apb_prdata[63:32] = 32'h1234_5678;
      #1 check("rd_arready", s_axi_arready, 1'b1);
      tick(); s_axi_arvalid = 1'b0;
      check("rd_setup_psel", m_apb_psel, 4'b0010);
      check("rd_setup_penable", m_apb_penable, 1'b0);
      check("rd_setup_paddr", m_apb_paddr, 32'h4000_1004);
      check("rd_setup_ctrl", {m_apb_pwrite, m_apb_pstrb}, 5'b0_0000);
      tick();
      check("rd_access_penable", m_apb_penable, 1'b1);
      check("rd_access_rvalid", s_axi_rvalid, 1'b0);
      tick();
      check("rd_rvalid", s_axi_rvalid, 1'b1);
      check("rd_rdata", s_axi_rdata, 32'h1234_5678);
      check("rd_rresp", s_axi_rresp, 2'b00);
      check("rd_apb_idle", {m_apb_psel, m_apb_penable}, 5'b0);
      tick();
      check("rd_done", s_axi_rvalid, 1'b0);

      // Write to slave 3 with 3 wait states and PSLVERR
      m_apb_pready = '0; s_axi_bready = 1'b0;
      s_axi_awaddr = 32'h4000_3000; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hA5A5_A5A5; s_axi_wstrb = 4'b0011; s_axi_wvalid = 1'b1;
      #1 check("wr_aw_w_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b110);
      tick(); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("wr_setup_psel", m_apb_psel, 4'b1000);
      check("wr_setup_ctrl", {m_apb_pwrite, m_apb_pstrb, m_apb_penable}, 6'b1_0011_0);
      check("wr_setup_data", {m_apb_paddr, m_apb_pwdata}, {32'h4000_3000, 32'hA5A5_A5A5});
      tick();
      check("wr_t2_penable", m_apb_penable, 1'b1);
      tick(); tick();
      check("wr_t4_wait", {m_apb_penable, s_axi_bvalid}, 2'b10);
      tick();
      m_apb_pready = 4'b1000; m_apb_pslverr = 4'b1000;
      check("wr_t5_wait", {m_apb_penable, s_axi_bvalid}, 2'b10);
      tick();
      m_apb_pready = '0; m_apb_pslverr = '0;
      check("wr_t6_bvalid", s_axi_bvalid, 1'b1);
      check("wr_t6_bresp", s_axi_bresp, 2'b10);
      check("wr_t6_psel", m_apb_psel, 4'b0000);
      tick();
      check("wr_bvalid_hold", {s_axi_bvalid, s_axi_bresp}, 3'b110);
      s_axi_bready = 1'b1;
      tick();
      check("wr_done", s_axi_bvalid, 1'b0);
      check("wr_paddr_hold", m_apb_paddr, 32'h4000_3000);

      // Decode misses
      s_axi_araddr = 32'h4000_4000; s_axi_arvalid = 1'b1;
      #1 check("miss_rd_arready", s_axi_arready, 1'b1);
      tick(); s_axi_arvalid = 1'b0;
      check("miss_rd_resp", {s_axi_rvalid, s_axi_rresp}, 3'b111);
      check("miss_rd_rdata", s_axi_rdata, 32'h0);
      check("miss_rd_psel", m_apb_psel, 4'b0000);
      tick();
      check("miss_rd_done", s_axi_rvalid, 1'b0);
      s_axi_awaddr = 32'h3FFF_FFFC; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      #1 check("miss_wr_awready", s_axi_awready, 1'b1);
      tick(); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("miss_wr_resp", {s_axi_bvalid, s_axi_bresp}, 3'b111);
      check("miss_wr_psel", m_apb_psel, 4'b0000);
      tick();
      check("miss_wr_done", s_axi_bvalid, 1'b0);

      // Both kinds held from reset: grants must alternate starting with read
      idle_inputs();
      m_apb_pready = 4'b1111;
      s_axi_araddr = 32'h4000_0000; s_axi_arvalid = 1'b1;
      s_axi_awaddr = 32'h4000_2000; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      rst = 1'b1;
      tick(); tick();
      check("arb_reset_ready", {s_axi_arready, s_axi_awready}, 2'b00);
      rst = 1'b0;
      #1;
      exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
      grants = 0; both = 0;
      for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
         if (s_axi_arready && s_axi_awready) both++;
         if (s_axi_arready || s_axi_awready) begin
            check("arb_grant_kind", s_axi_awready, exp_q.pop_front());
            grants++;
         end
         if (grants < 4) tick();
      end
      check("arb_grant_count", grants, 4);
      check("arb_no_double", both, 0);
      idle_inputs();
      tick(); tick();

      // PREADY timeout on slave 0
      s_axi_rready = 1'b0;
      s_axi_araddr = 32'h4000_0010; s_axi_arvalid = 1'b1;
      #1 check("to_arready", s_axi_arready, 1'b1);
      tick(); s_axi_arvalid = 1'b0;
      pen_cnt = 0; to_cnt = 0; seen = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (m_apb_penable) pen_cnt++;
         if (timeout_flag) to_cnt++;
         if (s_axi_rvalid) begin
            seen = 1;
            break;
         end
         tick();
      end
      check("to_rvalid_seen", seen, 1);
      check("to_penable_cycles", pen_cnt, 8);
      check("to_flag_at_resp", to_cnt, 1);
      check("to_rresp", s_axi_rresp, 2'b10);
      check("to_rdata", s_axi_rdata, 32'hDEAD_BEEF);
      tick();
      check("to_flag_pulse", {timeout_flag, s_axi_rvalid}, 2'b01);
      s_axi_rready = 1'b1;
      tick();
      check("to_done", s_axi_rvalid, 1'b0);

      // Reset during ACCESS of a write, then a normal read
      s_axi_awaddr = 32'h4000_2000; s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      #1 check("rst_wr_awready", s_axi_awready, 1'b1);
      tick(); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      tick();
      check("rst_wr_access", {m_apb_psel, m_apb_penable}, 5'b0100_1);
      rst = 1'b1;
      tick();
      check("rst_mid_outputs", all_outputs(), '0);
      rst = 1'b0;
      tick(); tick();
      check("rst_no_bvalid", s_axi_bvalid, 1'b0);
      check("rst_state_idle", fsm_state, 2'd0);
      m_apb_pready = 4'b0010; m_apb_prdata[63:32] = 32'hCAFE_0001;
      s_axi_araddr = 32'h4000_1008; s_axi_arvalid = 1'b1;
      #1 check("post_rst_arready", s_axi_arready, 1'b1);
      tick(); s_axi_arvalid = 1'b0;
      tick(); tick();
      check("post_rst_rvalid", {s_axi_rvalid, s_axi_rresp}, 3'b100);
      check("post_rst_rdata", s_axi_rdata, 32'hCAFE_0001);
      check("post_rst_paddr", m_apb_paddr, 32'h4000_1008);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/axi_lite_apb_bridge_n.md
Name: axi_lite_apb_bridge_n

Overview:
Parametrised AXI-Lite slave to multi-port APB3/APB4 master bridge for the Panda RISC-V SoC peripheral bus. It supersedes the fixed 4-slave bridge with a configurable slave count and a uniform slot map. It adds round-robin read/write arbitration, per-access PREADY timeout and DECERR for unmapped addresses. It sits between the core's data-bus AXI port and the APB peripherals (GPIO, I2C, TIMER, UART, ...).

Parameters:
apb_slave_n, 4, number of APB slave ports (1..16)
apb_base_addr, 32'h4000_0000, base address of slot 0
apb_slot_log2, 12, log2 of each slot size in bytes; slot i = base + i<<apb_slot_log2
pready_timeout_th, 64, max ACCESS cycles waiting for pready (>=2); 0 disables the timeout
simulation_delay, 0, register-assignment delay for simulation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_araddr/arvalid/arready  in/in/out  32/1/1  AXI-Lite read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
s_axi_awaddr/awvalid/awready  in/in/out  32/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
m_apb_paddr  out  32  shared address (full AXI address)
m_apb_pwrite/penable  out  1/1  shared APB controls
m_apb_pstrb/pwdata  out  4/32  shared write strobe and data (pstrb = 0 on reads)
m_apb_pprot  out  3  constant 3'b000
m_apb_psel  out  apb_slave_n  one-hot select
m_apb_pready/pslverr  in  apb_slave_n each  per-slave ready and error
m_apb_prdata  in  32*apb_slave_n  per-slave read data, slave i at bits [32i+31:32i]
timeout_flag  out  1  one-cycle pulse on a timeout abort

Behaviour:
- Reset: on clk edge with rst=1, state=IDLE. All outputs are 0: arready, awready, wready, rvalid, bvalid, psel, penable, pwrite, paddr, pwdata, pstrb, rdata, rresp, bresp, timeout_flag. Reset mid-transfer abandons the transfer; no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP. One transaction is outstanding at a time.
- Write request is valid only when awvalid && wvalid. Read request = arvalid.
- IDLE arbitration:
  - Only one kind pending: grant it.
  - Both pending: grant the kind not granted last (round-robin). After reset, read has priority.
- IDLE handshakes (combinational):
  - arready = IDLE && read granted.
  - awready = wready = IDLE && write granted; AW and W complete in the same cycle.
  - Address, wdata and wstrb are captured on the handshake.
- Decode: idx = (addr - apb_base_addr) >> apb_slot_log2, computed with 32-bit unsigned wrap.
  - Hit if addr >= base and idx < apb_slave_n.
  - Miss: go straight to RESP with resp = 2'b11 (DECERR). rdata = 0. No APB activity.
  - Hit: go to SETUP.
- SETUP (1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb valid; next state ACCESS.
- ACCESS: penable=1.
  - On pready[idx]=1: capture prdata[idx]; resp = pslverr[idx] ? 2'b10 : 2'b00. Drop psel/penable next cycle; go to RESP.
  - Wait counter increments each ACCESS cycle. If it reaches pready_timeout_th without pready: drop psel/penable, pulse timeout_flag, resp = 2'b10, rdata = 32'hDEAD_BEEF, go to RESP.
  - Counter clears on entering SETUP.
- RESP:
  - Read: rvalid=1, held with stable rdata/rresp until rready.
  - Write: bvalid=1, held until bready.
  - On handshake, return to IDLE; the next grant is possible in the following cycle.
- Latency (zero-wait slave, ready consumer): handshake at T, SETUP T+1, ACCESS T+2, rvalid/bvalid T+3. Decode miss: response at T+1.
- paddr, pwdata and pstrb hold their last value after a transfer (no forced zero).
- pslverr and prdata from non-selected slaves are ignored.

Test Plan:
- Read 0x4000_1004, slave1 pready=1 at first ACCESS with prdata=0x1234_5678 -> psel=4'b0010 at T+1, penable at T+2, rvalid at T+3 with rdata=0x1234_5678, rresp=0.
- Write 0x4000_3000, wdata=0xA5A5_A5A5, wstrb=4'b0011; slave3 inserts 3 wait states, then pslverr=1 -> pwrite=1, pstrb=0011 on slave3; bvalid with bresp=2'b10 at T+6.
- Read 0x4000_4000 (idx 4 with apb_slave_n=4) and write 0x3FFF_FFFC -> no psel; rresp/bresp=2'b11 one cycle after handshake.
- arvalid and aw/wvalid held continuously from reset -> grants alternate read, write, read, write; never two of the same kind in a row.
- pready_timeout_th=8, slave0 never ready on read -> penable for exactly 8 cycles, timeout_flag pulses once, rresp=2'b10, rdata=0xDEAD_BEEF.
- rst asserted during ACCESS of a write -> next cycle all outputs 0, no bvalid; a following read completes normally.
